// File: rtl/s_mem_arbiter.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : s_mem_arbiter
// Purpose  : Locked-ownership arbiter sharing the single-port 256x8 S-array
//            RAM among the RC4 init (0), shuffle (1) and decrypt (2) engines.
//            Routes the owner's address/data/write-enable to the RAM and
//            returns read data with a per-requester valid strobe.
// Ports    : clok, rst           - clock, synchronous active-high reset
//            req/addr/wdata/wren - per-requester request and RAM access
//            gnt                 - registered one-hot grant
//            mem_addr/wdata/wren - RAM side (combinational mux on gnt)
//            mem_q, rdata        - RAM read data in, passed through out
//            rvalid              - registered one-hot read-data-valid
//            light               - status LEDs (100 idle, owner+1 owned)
// Config   : define ARB_ROUND_ROBIN_EN for round-robin arbitration;
//            default is fixed priority, index 0 highest.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
module s_mem_arbiter #(
   parameter int N_REQ = 3,
   parameter int AW    = 8,
   parameter int DW    = 8
) (
   input  logic                clok,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*AW-1:0] addr,
   input  logic [N_REQ*DW-1:0] wdata,
   input  logic [N_REQ-1:0]    wren,
   output logic [N_REQ-1:0]    gnt,
   output logic [AW-1:0]       mem_addr,
   output logic [DW-1:0]       mem_wdata,
   output logic                mem_wren,
   input  logic [DW-1:0]       mem_q,
   output logic [DW-1:0]       rdata,
   output logic [N_REQ-1:0]    rvalid,
   output logic [2:0]          light
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_OWNED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] rvalid_q, rvalid_d;
   logic [IW-1:0]    winner;
   logic [IW-1:0]    owner_idx;
   logic             any_req;
   logic             owner_req;

   assign any_req   = |req;
   // Ownership persists only while the current owner keeps its request up.
   assign owner_req = |(req & gnt_q);

`ifdef ARB_ROUND_ROBIN_EN
   // Pointer holds the index just after the last owner; search wraps from it.
   logic [IW-1:0] ptr_q, ptr_d;
   logic          rr_found;
   int            rr_idx;

   always_comb begin
      winner   = '0;
      rr_found = 1'b0;
      rr_idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         rr_idx = int'(ptr_q) + k;
         if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
         if (!rr_found && req[IW'(rr_idx)]) begin
            winner   = IW'(rr_idx);
            rr_found = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (state_q == S_IDLE && any_req)
         ptr_d = (winner == IW'(N_REQ-1)) ? '0 : winner + 1'b1;
   end

   always_ff @(posedge clok) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`else
   // Fixed priority: scanning downward leaves the lowest requesting index.
   always_comb begin
      winner = '0;
      for (int i = N_REQ-1; i >= 0; i--)
         if (req[i]) winner = IW'(i);
   end
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      case (state_q)
         S_IDLE: begin
            gnt_d = '0;
            if (any_req) begin
               gnt_d   = N_REQ'(1) << winner;
               state_d = S_OWNED;
            end
         end
         S_OWNED: begin
            if (!owner_req) begin
               gnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // A read is any owner cycle with request up and write-enable low.
   assign rvalid_d = gnt_q & req & ~wren;

   always_ff @(posedge clok) begin
      if (rst) begin
         state_q  <= S_IDLE;
         gnt_q    <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
      end
   end

   // AND-OR mux keyed by the registered one-hot grant; zero when no owner,
   // so non-owner write enables can never reach the RAM.
   logic [N_REQ:0][AW-1:0] addr_acc;
   logic [N_REQ:0][DW-1:0] wdata_acc;

   assign addr_acc[0]  = '0;
   assign wdata_acc[0] = '0;

   for (genvar g = 0; g < N_REQ; g++) begin : g_route
      assign addr_acc[g+1]  = addr_acc[g]  | (gnt_q[g] ? addr[g*AW +: AW]  : '0);
      assign wdata_acc[g+1] = wdata_acc[g] | (gnt_q[g] ? wdata[g*DW +: DW] : '0);
   end

   assign mem_addr  = addr_acc[N_REQ];
   assign mem_wdata = wdata_acc[N_REQ];
   assign mem_wren  = |(gnt_q & wren);

   always_comb begin
      owner_idx = '0;
      for (int i = 0; i < N_REQ; i++)
         if (gnt_q[i]) owner_idx = IW'(i);
   end

   assign light  = (gnt_q == '0) ? 3'b100 : 3'(int'(owner_idx) + 1);
   assign gnt    = gnt_q;
   assign rvalid = rvalid_q;
   assign rdata  = mem_q;

endmodule
`default_nettype wire

// File: tb/tb_s_mem_arbiter.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : tb_s_mem_arbiter
// Purpose  : Self-checking bench for s_mem_arbiter: directed vector table,
//            hand-written corner sequences and randomized traffic against a
//            transaction-level ownership/memory model.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
module tb_s_mem_arbiter;

   logic        clok = 1'b0;
   logic        rst;
   logic [2:0]  req, wren;
   logic [23:0] addr, wdata;
   logic [2:0]  gnt, rvalid, light;
   logic [7:0]  mem_addr, mem_wdata, mem_q, rdata;
   logic        mem_wren;

   always #5 clok = ~clok;

   s_mem_arbiter #(.N_REQ(3), .AW(8), .DW(8)) dut (
      .clok(clok), .rst(rst), .req(req), .addr(addr), .wdata(wdata),
      .wren(wren), .gnt(gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wren(mem_wren), .mem_q(mem_q), .rdata(rdata), .rvalid(rvalid),
      .light(light)
   );

   // Behavioural 256x8 synchronous RAM, read-before-write.
   logic [7:0] ram [256];
   logic [7:0] ram_q;
   always @(posedge clok) begin
      if (mem_wren === 1'b1) ram[mem_addr] <= mem_wdata;
      ram_q <= ram[mem_addr];
   end
   assign mem_q = ram_q;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int         m_owner = -1;   // -1 means nobody owns the RAM
   int         m_ptr   = 0;
   logic [2:0] m_rvalid = '0;
   logic [7:0] m_rdata  = '0;
   logic [7:0] m_mem [256];

   function automatic logic [7:0] a_of(input int i);
      return addr[i*8 +: 8];
   endfunction
   function automatic logic [7:0] d_of(input int i);
      return wdata[i*8 +: 8];
   endfunction

   function automatic logic [2:0] exp_gnt();
      return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
   endfunction
   function automatic logic [2:0] exp_light();
      return (m_owner < 0) ? 3'b100 : 3'(m_owner + 1);
   endfunction

   // One clock edge of the arbitration rules applied to the sampled inputs.
   task automatic model_update();
      int o = m_owner;
      int w = -1;
      m_rvalid = 3'b000;
      if (o >= 0) begin
         if (!wren[o]) m_rdata = m_mem[a_of(o)];
         if (!rst && req[o] && !wren[o]) m_rvalid = 3'(1 << o);
         if (wren[o]) m_mem[a_of(o)] = d_of(o);
      end
      if (rst) begin
         m_owner = -1;
         m_ptr   = 0;
      end else if (o < 0) begin
`ifdef ARB_ROUND_ROBIN_EN
         for (int k = 0; k < 3; k++) begin
            int j = (m_ptr + k) % 3;
            if (w < 0 && req[j]) w = j;
         end
         if (w >= 0) m_ptr = (w + 1) % 3;
`else
         for (int k = 2; k >= 0; k--) if (req[k]) w = k;
`endif
         m_owner = w;
      end else if (!req[o]) begin
         m_owner = -1;
      end
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic tick();
      @(posedge clok);
      model_update();
      #1;
   endtask

   task automatic check_comb_model();
      chk("mem_wren", mem_wren, (m_owner < 0) ? 1'b0 : wren[m_owner]);
      chk("mem_addr", mem_addr, (m_owner < 0) ? 8'h00 : a_of(m_owner));
      chk("mem_wdata", mem_wdata, (m_owner < 0) ? 8'h00 : d_of(m_owner));
   endtask

   task automatic check_regs_model();
      chk("gnt", gnt, exp_gnt());
      chk("rvalid", rvalid, m_rvalid);
      chk("light", light, exp_light());
      if (m_rvalid != 3'b000) chk("rdata", rdata, m_rdata);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst;
      logic [2:0]  req;
      logic [2:0]  wren;
      logic [23:0] addr;
      logic        chk_pre;
      logic        pre_wren;
      logic [7:0]  pre_addr;
      logic [2:0]  gnt;
      logic [2:0]  rvalid;
      logic [2:0]  light;
   } vec_t;

   vec_t tbl [12];

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]   = 8'h00;
         m_mem[i] = 8'h00;
      end
      rst = 1'b1; req = '0; wren = '0; addr = '0; wdata = 24'hC3B2A1;

      //          rst   req     wren    addr        pre  pwr  paddr  gnt     rvalid  light
      tbl[0]  = '{1'b1, 3'b111, 3'b000, 24'h000000, 1'b0, 1'b0, 8'h00, 3'b000, 3'b000, 3'b100};
      tbl[1]  = '{1'b1, 3'b111, 3'b000, 24'h030201, 1'b1, 1'b0, 8'h00, 3'b000, 3'b000, 3'b100};
      tbl[2]  = '{1'b0, 3'b111, 3'b000, 24'h030201, 1'b1, 1'b0, 8'h00, 3'b001, 3'b000, 3'b001};
      tbl[3]  = '{1'b0, 3'b000, 3'b000, 24'h030201, 1'b1, 1'b0, 8'h01, 3'b000, 3'b000, 3'b100};
      tbl[4]  = '{1'b0, 3'b100, 3'b000, 24'h030201, 1'b1, 1'b0, 8'h00, 3'b100, 3'b000, 3'b011};
      tbl[5]  = '{1'b0, 3'b101, 3'b101, 24'h440033, 1'b1, 1'b1, 8'h44, 3'b100, 3'b000, 3'b011};
      tbl[6]  = '{1'b0, 3'b101, 3'b001, 24'h450033, 1'b1, 1'b0, 8'h45, 3'b100, 3'b100, 3'b011};
      tbl[7]  = '{1'b0, 3'b101, 3'b101, 24'h460033, 1'b1, 1'b1, 8'h46, 3'b100, 3'b000, 3'b011};
      tbl[8]  = '{1'b0, 3'b001, 3'b001, 24'h460033, 1'b1, 1'b0, 8'h46, 3'b000, 3'b000, 3'b100};
      tbl[9]  = '{1'b0, 3'b001, 3'b001, 24'h460033, 1'b1, 1'b0, 8'h00, 3'b001, 3'b000, 3'b001};
      tbl[10] = '{1'b0, 3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 8'h00, 3'b000, 3'b000, 3'b100};
      tbl[11] = '{1'b0, 3'b110, 3'b000, 24'h000000, 1'b1, 1'b0, 8'h00, 3'b010, 3'b000, 3'b010};

      @(posedge clok); #1;
      for (int i = 0; i < 12; i++) begin
         rst = tbl[i].rst; req = tbl[i].req; wren = tbl[i].wren; addr = tbl[i].addr;
         settle();
         if (tbl[i].chk_pre) begin
            chk($sformatf("tbl%0d_mem_wren", i), mem_wren, tbl[i].pre_wren);
            chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].pre_addr);
         end
         tick();
         chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
         chk($sformatf("tbl%0d_rvalid", i), rvalid, tbl[i].rvalid);
         chk($sformatf("tbl%0d_light", i), light, tbl[i].light);
      end

      // ---- single owner write then reads (owner 1 already granted) ----
      req = 3'b010; wren = 3'b010; addr = 24'h001000; wdata = 24'h00A500;
      settle();
      chk("wr_mem_wren", mem_wren, 1'b1);
      chk("wr_mem_addr", mem_addr, 8'h10);
      chk("wr_mem_wdata", mem_wdata, 8'hA5);
      tick();
      chk("wr_gnt", gnt, 3'b010);
      chk("wr_light", light, 3'b010);
      wren = 3'b000;
      settle();
      chk("rd_mem_wren", mem_wren, 1'b0);
      tick();
      chk("rd_rvalid", rvalid, 3'b010);
      chk("rd_rdata", rdata, 8'hA5);
      chk("rd_light", light, 3'b010);
      addr = 24'h004400;                 // back-to-back read of earlier write
      settle(); tick();
      chk("rd2_rvalid", rvalid, 3'b010);
      chk("rd2_rdata", rdata, 8'hC3);

      // ---- reset with a read in flight ----
      addr = 24'h001000; rst = 1'b1;
      settle(); tick();
      chk("rst_gnt", gnt, 3'b000);
      chk("rst_rvalid", rvalid, 3'b000);
      chk("rst_light", light, 3'b100);
      rst = 1'b0; req = 3'b000;
      settle(); tick();
      chk("post_rst_gnt", gnt, 3'b000);
      chk("post_rst_rvalid", rvalid, 3'b000);

      // ---- simultaneous requests and policy after release ----
      req = 3'b110;
      settle(); tick();
      chk("sim_gnt", gnt, 3'b010);
      req = 3'b000;
      settle(); tick();
      chk("release_gnt", gnt, 3'b000);
      req = 3'b111;
      settle(); tick();
`ifdef ARB_ROUND_ROBIN_EN
      chk("policy_gnt", gnt, 3'b100);
`else
      chk("policy_gnt", gnt, 3'b001);
`endif
      req = 3'b000;
      settle(); tick();

      // ---- randomized traffic against the model ----
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(63) == 0);
         for (int r = 0; r < 3; r++) begin
            if ($urandom_range(7) == 0) req[r] = ~req[r];
            wren[r]          = $urandom_range(1);
            addr[r*8 +: 8]   = 8'($urandom_range(15));
            wdata[r*8 +: 8]  = 8'($urandom);
         end
         settle();
         check_comb_model();
         tick();
         check_regs_model();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
